// File: rtl/parity_pkg.sv
// parity_pkg: shared parity constants, scrub FSM states and width helper
package parity_pkg;
  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD = 1'b1;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/parity_gen.sv
// parity_gen: parity bit that makes data plus parity match the selected sense
module parity_gen #(
  parameter int WIDTH = 8,
  parameter bit ODD = 1'b0
)(
  input  logic [WIDTH-1:0] data,
  output logic             par
);
  assign par = ^data ^ ODD;
endmodule

// File: rtl/parity_scrub_mem.sv
// parity_scrub_mem: parity-protected multi-bank memory with a scrub engine
module parity_scrub_mem
  import parity_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int BANKS = 2,
  parameter bit ODD = PAR_EVEN,
  localparam int AW = clog2_min1(DEPTH),
  localparam int BW = clog2_min1(BANKS),
  localparam int CW = $clog2(BANKS*DEPTH+1)
)(
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [BW-1:0]    wr_bank,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_inject,
  input  logic             rd_req,
  input  logic [BW-1:0]    rd_bank,
  input  logic [AW-1:0]    rd_addr,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_perr,
  input  logic             scan_start,
  output logic             scan_busy,
  output logic             scan_done,
  output logic [CW-1:0]    err_count,
  output logic             err_valid,
  output logic [BW-1:0]    err_bank,
  output logic [AW-1:0]    err_addr
);
  localparam int N = BANKS*DEPTH;
  localparam int IW = clog2_min1(N);

  logic [WIDTH-1:0] mem_d [N];
  logic             mem_p [N];
  state_t           state, next;
  logic [BW-1:0]    s_bank;
  logic [AW-1:0]    s_addr;
  logic [IW-1:0]    wr_idx, rd_idx, s_idx;
  logic             wr_ok, rd_ok, wr_par, rd_par, s_par, s_perr, last, rd_go;

  assign wr_ok = int'(wr_bank) < BANKS && int'(wr_addr) < DEPTH;
  assign rd_ok = int'(rd_bank) < BANKS && int'(rd_addr) < DEPTH;
  assign wr_idx = IW'(int'(wr_bank)*DEPTH + int'(wr_addr));
  assign rd_idx = IW'(int'(rd_bank)*DEPTH + int'(rd_addr));
  assign s_idx = IW'(int'(s_bank)*DEPTH + int'(s_addr));
  assign last = s_bank == BW'(BANKS-1) && s_addr == AW'(DEPTH-1);
  assign s_perr = s_par ^ mem_p[s_idx];
  assign scan_busy = state == SCAN;
  assign scan_done = state == DONE;
  assign rd_go = rd_req && !scan_busy;

  parity_gen #(.WIDTH(WIDTH), .ODD(ODD)) u_wr_par (.data(wr_data), .par(wr_par));
  parity_gen #(.WIDTH(WIDTH), .ODD(ODD)) u_rd_par (.data(mem_d[rd_idx]), .par(rd_par));
  parity_gen #(.WIDTH(WIDTH), .ODD(ODD)) u_scan_par (.data(mem_d[s_idx]), .par(s_par));

  // storage: reset to consistent zero words, writes accepted in every state
  always_ff @(posedge clk or negedge rstn)
    if (!rstn)
      for (int i = 0; i < N; i++) begin
        mem_d[i] <= '0;
        mem_p[i] <= ODD;
      end
    else if (wr_en && wr_ok) begin
      mem_d[wr_idx] <= wr_data;
      mem_p[wr_idx] <= wr_par ^ wr_inject;
    end

  // read port: one-cycle registered read, suppressed while scrubbing
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      rd_valid <= 1'b0;
      rd_data <= '0;
      rd_perr <= 1'b0;
    end else begin
      rd_valid <= rd_go;
      if (rd_go) begin
        rd_data <= rd_ok ? mem_d[rd_idx] : '0;
        rd_perr <= rd_ok && (rd_par ^ mem_p[rd_idx]);
      end
    end

  // scrub state register
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= next;

  // scrub next state: start only from idle, finish after the last word
  always_comb begin
    next = state;
    next = (state == IDLE && scan_start) ? SCAN :
           (state == SCAN && last) ? DONE :
           (state == DONE) ? IDLE : state;
  end

  // scrub walk: bank-major index, error count and first-failure capture
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      s_bank <= '0;
      s_addr <= '0;
      err_count <= '0;
      err_valid <= 1'b0;
      err_bank <= '0;
      err_addr <= '0;
    end else if (state == IDLE && scan_start) begin
      s_bank <= '0;
      s_addr <= '0;
      err_count <= '0;
      err_valid <= 1'b0;
      err_bank <= '0;
      err_addr <= '0;
    end else if (state == SCAN) begin
      if (s_perr) begin
        err_count <= err_count + 1'b1;
        if (!err_valid) begin
          err_valid <= 1'b1;
          err_bank <= s_bank;
          err_addr <= s_addr;
        end
      end
      s_addr <= (s_addr == AW'(DEPTH-1)) ? '0 : s_addr + 1'b1;
      s_bank <= (s_addr == AW'(DEPTH-1)) ? s_bank + 1'b1 : s_bank;
    end
endmodule
